// File: rtl/y86_wb_regfile_if.sv
// ============================================================================
// y86_wb_regfile_if : W-stage register, read ports and status bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface y86_wb_regfile_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       w_stat;
  logic [3:0]       w_icode;
  logic [31:0]      w_valE;
  logic [31:0]      w_valM;
  logic [3:0]       w_dstE;
  logic [3:0]       w_dstM;
  logic             w_Cnd;
  logic [3:0]       srcA;
  logic [3:0]       srcB;
  logic [31:0]      valA;
  logic [31:0]      valB;
  logic [2:0]       dbg_sel;
  logic [31:0]      dbg_val;
  logic [3:0]       cpu_stat;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output w_stat, w_icode, w_valE, w_valM, w_dstE, w_dstM, w_Cnd,
    output srcA, srcB, dbg_sel,
    input  valA, valB, dbg_val, cpu_stat, halted, retired
  );

  modport slave (
    input  w_stat, w_icode, w_valE, w_valM, w_dstE, w_dstM, w_Cnd,
    input  srcA, srcB, dbg_sel,
    output valA, valB, dbg_val, cpu_stat, halted, retired
  );
endinterface

`default_nettype wire

// File: rtl/y86_wb_regfile.sv
// ============================================================================
// y86_wb_regfile : Y86 writeback commit, 8-entry register file, CPU status
// Revision: 1.0
// ============================================================================
`default_nettype none

module y86_wb_regfile #(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input  wire                   clk,
  input  wire                   reset,
  y86_wb_regfile_if.slave       bus
);

  localparam logic [3:0] c_I_NOP    = 4'h1;
  localparam logic [3:0] c_I_RRMOVL = 4'h2;
  localparam logic [3:0] c_S_OK     = 4'h1;
  localparam logic [3:0] c_S_HLT    = 4'h2;
  localparam logic [3:0] c_S_ADR    = 4'h3;
  localparam logic [3:0] c_S_INS    = 4'h4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_exit_stat;
  logic [31:0]      r_regs [8];
  logic [CNT_W-1:0] r_retired;

  logic             w_ce;
  logic             w_we_e;
  logic             w_we_m;
  logic             w_retire;
  logic [31:0]      w_val_a;
  logic [31:0]      w_val_b;

  // Codes 8..15 have bit 3 set: R_NONE and out-of-range codes never write.
  assign w_ce     = (r_state == ST_RUN) && (bus.w_stat == c_S_OK);
  assign w_we_e   = w_ce && !bus.w_dstE[3] && !((bus.w_icode == c_I_RRMOVL) && !bus.w_Cnd);
  assign w_we_m   = w_ce && !bus.w_dstM[3];
  assign w_retire = w_ce && (bus.w_icode != c_I_NOP);

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_RUN) begin
      if (bus.w_stat == c_S_HLT)
        w_state_nxt = ST_HALTED;
      else if ((bus.w_stat == c_S_ADR) || (bus.w_stat == c_S_INS))
        w_state_nxt = ST_FAULT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_exit_stat <= c_S_OK;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_RUN) && (w_state_nxt != ST_RUN))
        r_exit_stat <= bus.w_stat;
    end
  end

  // E is written first so that a shared destination ends up holding valM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++)
        r_regs[i] <= '0;
    end else begin
      if (w_we_e)
        r_regs[bus.w_dstE[2:0]] <= bus.w_valE;
      if (w_we_m)
        r_regs[bus.w_dstM[2:0]] <= bus.w_valM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_retired <= '0;
    else if (w_retire)
      r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    w_val_a = bus.srcA[3] ? 32'd0 : r_regs[bus.srcA[2:0]];
    w_val_b = bus.srcB[3] ? 32'd0 : r_regs[bus.srcB[2:0]];
    if (BYPASS != 0) begin
      if (w_we_e && (bus.w_dstE == bus.srcA)) w_val_a = bus.w_valE;
      if (w_we_m && (bus.w_dstM == bus.srcA)) w_val_a = bus.w_valM;
      if (w_we_e && (bus.w_dstE == bus.srcB)) w_val_b = bus.w_valE;
      if (w_we_m && (bus.w_dstM == bus.srcB)) w_val_b = bus.w_valM;
    end
  end

  assign bus.valA     = w_val_a;
  assign bus.valB     = w_val_b;
  assign bus.dbg_val  = r_regs[bus.dbg_sel];
  assign bus.cpu_stat = (r_state == ST_RUN) ? c_S_OK : r_exit_stat;
  assign bus.halted   = (r_state != ST_RUN);
  assign bus.retired  = r_retired;

endmodule

`default_nettype wire
